pattern_scheduler: RTL and testbench

Frame-rate controller that sequences the background pattern generator through its patterns automatically. It holds each pattern for a programmable dwell time, then runs a fade-out / switch / fade-in transition. It also handles pause/resume and a debounced manual "skip" button. It sits between the VGA timing generator (consumes `frame_start`) and the pattern selector / final RGB mux (drives `pattern_select` and a dimming level).

---
 rtl/pattern_scheduler_pkg.sv | 20 ++
 rtl/pattern_scheduler_if.sv | 23 ++
 rtl/pattern_scheduler_debouncer.sv | 36 +++
 rtl/pattern_scheduler.sv | 179 +++++++++++++++++
 tb/tb_pattern_scheduler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scheduler_pkg.sv
// Shared types and constants for the pattern scheduler.
package pattern_sched_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2,
    PAUSED   = 2'd3
  } state_t;

  localparam int unsigned PAT_W  = 2;
  localparam int unsigned FADE_W = 2;
  localparam logic [FADE_W-1:0] FADE_MAX = 2'd3;

  // Counter width for a 0..n-1 count, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_scheduler_if.sv
// Frame-rate control bus between timing generator, scheduler and RGB mux.
interface pattern_scheduler_if;
  import pattern_sched_pkg::*;

  logic              frame_start;
  logic              pause;
  logic              resume;
  logic              skip;
  logic [PAT_W-1:0]  pattern_select;
  logic [FADE_W-1:0] fade_level;
  logic              paused;
  logic              advance;

  modport master (
    output frame_start, pause, resume, skip,
    input  pattern_select, fade_level, paused, advance
  );

  modport slave (
    input  frame_start, pause, resume, skip,
    output pattern_select, fade_level, paused, advance
  );
endinterface

// File: rtl/pattern_scheduler_debouncer.sv
// Skip button debouncer: counts consecutive high frame samples, strobes once on the debounced rise.
module skip_debouncer
  import pattern_sched_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic skip,
  output logic event_c
);
  localparam int unsigned CNT_W = cnt_w(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [CNT_W-1:0] cnt;
  logic             level;

  // Strobe fires in the frame of the final qualifying sample so the FSM reacts immediately.
  assign event_c = en & skip & ~level & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (en) begin
      if (!skip) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (!level) begin
        if (cnt == CNT_LAST) level <= 1'b1;
        else                 cnt   <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/pattern_scheduler.sv
// Pattern scheduler: dwell, fade-out / switch / fade-in sequencing with pause and debounced skip.
// Define PATTERN_SCHED_FADE_EN to build the fade transitions; otherwise patterns switch directly.
module pattern_scheduler
  import pattern_sched_pkg::*;
#(
  parameter int unsigned DWELL_FRAMES     = 300,
  parameter int unsigned FADE_STEP_FRAMES = 4,
  parameter int unsigned NUM_PATTERNS     = 4,
  parameter int unsigned DEBOUNCE_FRAMES  = 3
) (
  input logic                clk,
  input logic                rst,
  pattern_scheduler_if.slave bus
);
  localparam int unsigned DWELL_W = cnt_w(DWELL_FRAMES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
  localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

  state_t             state, state_nxt, saved, saved_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic [PAT_W-1:0]   pattern, pattern_nxt, pattern_inc;
  logic               paused_q, paused_nxt;
  logic               advance_q, advance_nxt;
  logic               skip_ev, pause_in, hold, resume_ok, dwell_done;

`ifdef PATTERN_SCHED_FADE_EN
  localparam int unsigned STEP_W = cnt_w(FADE_STEP_FRAMES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);

  logic [STEP_W-1:0] step, step_nxt;
  logic [FADE_W-1:0] fade, fade_nxt;
  logic              step_done;

  assign step_done = (step == STEP_LAST);
`endif

  skip_debouncer #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_skip (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.frame_start),
    .skip    (bus.skip),
    .event_c (skip_ev)
  );

  // Pause entry is folded into the same frame so a coincident skip follows paused rules.
  assign pause_in    = bus.frame_start & bus.pause & (state != PAUSED);
  assign hold        = (state == PAUSED) | pause_in;
  assign resume_ok   = (state == PAUSED) & bus.resume & ~bus.pause;
  assign dwell_done  = (dwell == DWELL_LAST);
  assign pattern_inc = (pattern == PAT_LAST) ? '0 : pattern + PAT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHOW;
      saved <= SHOW;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    saved_nxt = saved;
    if (bus.frame_start) begin
      if (hold) begin
        if (pause_in) saved_nxt = state;
        if (skip_ev)  saved_nxt = SHOW;
        state_nxt = resume_ok ? (skip_ev ? SHOW : saved) : PAUSED;
      end else begin
`ifdef PATTERN_SCHED_FADE_EN
        case (state)
          SHOW:     if (dwell_done || skip_ev)              state_nxt = FADE_OUT;
          FADE_OUT: if (step_done && (fade == FADE_MAX))    state_nxt = FADE_IN;
          FADE_IN:  if (step_done && (fade == FADE_W'(1)))  state_nxt = SHOW;
          default:  state_nxt = state;
        endcase
`else
        state_nxt = SHOW;
`endif
      end
    end
  end

  always_comb begin
    dwell_nxt   = dwell;
    pattern_nxt = pattern;
    paused_nxt  = paused_q;
    advance_nxt = 1'b0;
`ifdef PATTERN_SCHED_FADE_EN
    step_nxt    = step;
    fade_nxt    = fade;
`endif
    if (bus.frame_start) begin
      paused_nxt = (state_nxt == PAUSED);
      if (hold) begin
        if (skip_ev) begin
          pattern_nxt = pattern_inc;
          advance_nxt = 1'b1;
          dwell_nxt   = '0;
`ifdef PATTERN_SCHED_FADE_EN
          step_nxt    = '0;
          fade_nxt    = '0;
`endif
        end
      end else begin
`ifdef PATTERN_SCHED_FADE_EN
        case (state)
          SHOW: begin
            if (dwell_done || skip_ev) begin
              dwell_nxt = '0;
              step_nxt  = '0;
            end else begin
              dwell_nxt = dwell + DWELL_W'(1);
            end
          end
          FADE_OUT, FADE_IN: begin
            if (step_done) begin
              step_nxt = '0;
              if (state == FADE_IN) begin
                fade_nxt = fade - FADE_W'(1);
              end else if (fade != FADE_MAX) begin
                fade_nxt = fade + FADE_W'(1);
              end else begin
                pattern_nxt = pattern_inc;
                advance_nxt = 1'b1;
              end
            end else begin
              step_nxt = step + STEP_W'(1);
            end
          end
          default: ;
        endcase
`else
        if (dwell_done || skip_ev) begin
          dwell_nxt   = '0;
          pattern_nxt = pattern_inc;
          advance_nxt = 1'b1;
        end else begin
          dwell_nxt = dwell + DWELL_W'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= '0;
      pattern   <= '0;
      paused_q  <= 1'b0;
      advance_q <= 1'b0;
`ifdef PATTERN_SCHED_FADE_EN
      step      <= '0;
      fade      <= '0;
`endif
    end else begin
      dwell     <= dwell_nxt;
      pattern   <= pattern_nxt;
      paused_q  <= paused_nxt;
      advance_q <= advance_nxt;
`ifdef PATTERN_SCHED_FADE_EN
      step      <= step_nxt;
      fade      <= fade_nxt;
`endif
    end
  end

  assign bus.pattern_select = pattern;
  assign bus.paused         = paused_q;
  assign bus.advance        = advance_q;
`ifdef PATTERN_SCHED_FADE_EN
  assign bus.fade_level     = fade;
`else
  assign bus.fade_level     = '0;
`endif
endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler; expected frames come from a hand-written per-cycle table.
module tb_pattern_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_scheduler_if bus ();

  pattern_scheduler #(
    .DWELL_FRAMES     (4),
    .FADE_STEP_FRAMES (1),
    .NUM_PATTERNS     (4),
    .DEBOUNCE_FRAMES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef PATTERN_SCHED_FADE_EN
  localparam int CYC       = 11;
  localparam int ADV_IDX   = 7;
  localparam int PAUSE_PRE = 6;
  localparam int SKIPP_PRE = 29;
`else
  localparam int CYC       = 4;
  localparam int ADV_IDX   = 3;
  localparam int PAUSE_PRE = 2;
  localparam int SKIPP_PRE = 9;
`endif
  localparam int EXPIRE_IDX = 3;

  typedef struct packed {
    logic [15:0] id;
    logic [1:0]  pat;
    logic [1:0]  fade;
    logic        paused;
    logic        adv;
  } exp_t;

  int   fade_tab [CYC];
  exp_t sb [$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   adv_seen = 0;
  int   base;
  logic fs_d = 1'b0;
  logic fs_d2 = 1'b0;

  int m_pos, m_pat, m_fade, frame_no;
  bit m_paused;

  task automatic cmp(input string nm, input int id, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s frame %0d: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_pat = 0; m_fade = 0; m_paused = 1'b0;
  endtask

  // One frame: update the table model, queue the expectation, then pulse frame_start.
  task automatic frame(input bit p, input bit r, input bit s, input bit ev);
    exp_t e;
    bit   adv;
    adv = 1'b0;
    if (p || m_paused) begin
      if (ev) begin
        m_pat = (m_pat + 1) % 4; m_fade = 0; m_pos = 0; adv = 1'b1;
      end
      m_paused = !(m_paused && r && !p);
    end else begin
      if (ev) m_pos = EXPIRE_IDX;
      m_fade = fade_tab[m_pos];
      if (m_pos == ADV_IDX) begin
        adv = 1'b1; m_pat = (m_pat + 1) % 4;
      end
      m_pos = (m_pos + 1) % CYC;
    end
    frame_no++;
    e.id = 16'(frame_no); e.pat = 2'(m_pat); e.fade = 2'(m_fade);
    e.paused = m_paused; e.adv = adv;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.pause = p; bus.resume = r; bus.skip = s; bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0; bus.skip = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // Reset coincident with frame_start: reset must win and clear everything.
  task automatic rst_frame();
    exp_t e;
    frame_no++;
    e = '0;
    e.id = 16'(frame_no);
    sb.push_back(e);
    @(posedge clk); #1;
    rst = 1'b1; bus.frame_start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.frame_start = 1'b0;
    repeat (8) @(posedge clk);
    model_reset();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    cmp("rst_pattern", frame_no, int'(bus.pattern_select), 0);
    cmp("rst_fade",    frame_no, int'(bus.fade_level), 0);
    cmp("rst_paused",  frame_no, int'(bus.paused), 0);
    cmp("rst_advance", frame_no, int'(bus.advance), 0);
  endtask

  always @(posedge clk) begin
    fs_d  <= bus.frame_start;
    fs_d2 <= fs_d;
  end

  // Monitor: outputs are valid the cycle after each frame_start.
  always @(negedge clk) begin
    if (bus.advance) adv_seen++;
    if (fs_d) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL scoreboard_empty: got output with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        cmp("pattern_select", int'(mon_e.id), int'(bus.pattern_select), int'(mon_e.pat));
        cmp("fade_level",     int'(mon_e.id), int'(bus.fade_level),     int'(mon_e.fade));
        cmp("paused",         int'(mon_e.id), int'(bus.paused),         int'(mon_e.paused));
        cmp("advance",        int'(mon_e.id), int'(bus.advance),        int'(mon_e.adv));
      end
    end
    if (fs_d2) cmp("advance_one_clock", frame_no, int'(bus.advance), 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.frame_start = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0; bus.skip = 1'b0;
    frame_no = 0;
`ifdef PATTERN_SCHED_FADE_EN
    fade_tab = '{0, 0, 0, 0, 1, 2, 3, 3, 2, 1, 0};
`else
    fade_tab = '{0, 0, 0, 0};
`endif
    model_reset();

    // Auto cycling and wrap over four full cycles
    do_reset();
    base = adv_seen;
    repeat (4 * CYC) frame(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cmp("wrap_pattern",  frame_no, int'(bus.pattern_select), 0);
    cmp("wrap_advances", frame_no, adv_seen - base, 4);

    // Single-frame skip is rejected
    do_reset();
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (CYC) frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Held skip from frame 2 gives exactly one event, on the second high sample
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) frame(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (CYC + 2) frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Pause mid-fade for ten frames, pause beats resume, then resume
    do_reset();
    repeat (PAUSE_PRE) frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Skip while paused advances immediately and restarts a full dwell
    do_reset();
    repeat (SKIPP_PRE) frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset at frame 9 dominates frame_start
    do_reset();
    repeat (8) frame(1'b0, 1'b0, 1'b0, 1'b0);
    rst_frame();
    repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (20) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
